// File: rtl/serial_capture_fifo.sv
// Captures an asynchronous serial bit stream into words and buffers them in a
// FIFO that is read one word per rising edge of an asynchronous read strobe.
//
// Ports:
//   clk           system clock, all state updates on its rising edge
//   rst_n         asynchronous active-low reset
//   ser_clk       external serial bit clock (async), bits taken on rising edge
//   ser_data      serial data (async), stable around ser_clk rising edges
//   enable        capture enable (sync to clk)
//   ready         read strobe (async), each rising edge requests one word
//   data          last word popped from the FIFO
//   data_valid    1 when the last read request returned a word
//   rpi_interrupt fill interrupt with IRQ_HIGH / IRQ_LOW hysteresis
//   level         number of words currently stored
//   overflow      sticky: a completed word was dropped because the FIFO was full
module serial_capture_fifo #(
  parameter int unsigned WORD_W    = 24,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned IRQ_HIGH  = 16,
  parameter int unsigned IRQ_LOW   = 0,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_clk,
  input  logic                     ser_data,
  input  logic                     enable,
  input  logic                     ready,
  output logic [WORD_W-1:0]        data,
  output logic                     data_valid,
  output logic                     rpi_interrupt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  // Synchroniser chains and edge-detect history
  logic [1:0] sclk_sync;
  logic [1:0] sdat_sync;
  logic [1:0] rdy_sync;
  logic       sclk_prev;
  logic       rdy_prev;

  // Word assembly
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] shift_q;

  // FIFO state
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  logic              sclk_rise_c;
  logic              rdy_rise_c;
  logic [CW-1:0]     bit_pos_c;
  logic [WORD_W-1:0] word_c;
  logic              last_bit_c;
  logic              push_c;
  logic              full_c;
  logic              empty_c;
  logic              pop_c;
  logic              wr_en_c;
  logic              drop_c;

  // Bring the asynchronous inputs into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      sdat_sync <= 2'b00;
      rdy_sync  <= 2'b00;
      sclk_prev <= 1'b0;
      rdy_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], ser_clk};
      sdat_sync <= {sdat_sync[0], ser_data};
      rdy_sync  <= {rdy_sync[0], ready};
      sclk_prev <= sclk_sync[1];
      rdy_prev  <= rdy_sync[1];
    end
  end

  // Edge detects, bit placement and FIFO control decisions
  always_comb begin
    sclk_rise_c = sclk_sync[1] & ~sclk_prev;
    rdy_rise_c  = rdy_sync[1] & ~rdy_prev;
    bit_pos_c   = (MSB_FIRST != 0) ? (CW'(WORD_W - 1) - bit_cnt) : bit_cnt;
    word_c      = shift_q;
    word_c[bit_pos_c] = sdat_sync[1];
    last_bit_c  = (bit_cnt == CW'(WORD_W - 1));
    // The completing bit is merged combinationally so the word is written on
    // the same edge that samples its last bit.
    push_c      = enable & sclk_rise_c & last_bit_c;
    full_c      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty_c     = (wr_ptr == rd_ptr);
    pop_c       = rdy_rise_c & ~empty_c;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    wr_en_c     = push_c & (~full_c | pop_c);
    drop_c      = push_c & full_c & ~pop_c;
  end

  // Bit counter and partial word; both clear while capture is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (!enable) begin
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (sclk_rise_c) begin
      if (last_bit_c) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        shift_q <= word_c;
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr[AW-1:0]] <= word_c;
    end
  end

  // Pointers, level, overflow and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      case ({wr_en_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (rdy_rise_c) begin
        data_valid <= ~empty_c;
        if (!empty_c) begin
          data <= mem[rd_ptr[AW-1:0]];
        end
      end
    end
  end

  // Fill interrupt with hysteresis, forced low while capture is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpi_interrupt <= 1'b0;
    end else if (!enable) begin
      rpi_interrupt <= 1'b0;
    end else if (level >= LW'(IRQ_HIGH)) begin
      rpi_interrupt <= 1'b1;
    end else if (level <= LW'(IRQ_LOW)) begin
      rpi_interrupt <= 1'b0;
    end
  end

endmodule
